// File: rtl/dbus_responder.sv
// Single-port data-bus responder: fixed-latency read/write into a 64-bit word store.
// Optional DBUS_RESP_ALIGN_CHK_EN adds misalign_err (msize encoding: 0=1B, 1=2B, 2=4B, 3=8B).
module dbus_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [63:0] resp_data
`ifdef DBUS_RESP_ALIGN_CHK_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

`ifdef DBUS_RESP_ALIGN_CHK_EN
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;
    localparam logic [2:0] MSIZE8 = 3'd3;

    function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [2:0] size);
        logic mis;
        case (size)
            MSIZE2:  mis = addr_lo[0];
            MSIZE4:  mis = |addr_lo[1:0];
            MSIZE8:  mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction
`endif

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [7:0]     strb_q, strb_d;
    logic [63:0]    wdata_q, wdata_d;
    logic           mis_q, mis_d;
    logic           data_ok_q, data_ok_d;
    logic [63:0]    rdata_q, rdata_d;
    logic           err_q, err_d;

    logic [63:0]    mem_q [DEPTH];

    logic [AW-1:0]  req_idx_s;
    logic           req_mis_s;
    logic           cm_en_s;
    logic [AW-1:0]  cm_idx_s;
    logic [7:0]     cm_strb_s;
    logic [63:0]    cm_data_s;
    logic           cm_mis_s;
    logic           unused_s;

    assign req_idx_s = req_addr[3 +: AW];

`ifdef DBUS_RESP_ALIGN_CHK_EN
    assign req_mis_s    = is_misaligned(req_addr[2:0], req_size);
    assign misalign_err = err_q;
    assign unused_s     = ^req_addr[63:3+AW];
`else
    assign req_mis_s    = 1'b0;
    assign unused_s     = ^{req_addr[63:3+AW], req_addr[2:0], req_size, err_q};
`endif

    // Next-state, capture and commit selection; a zero-latency request commits straight from the bus.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        strb_d    = strb_q;
        wdata_d   = wdata_q;
        mis_d     = mis_q;
        data_ok_d = 1'b0;
        rdata_d   = 64'd0;
        err_d     = 1'b0;
        cm_en_s   = 1'b0;
        cm_idx_s  = idx_q;
        cm_strb_s = strb_q;
        cm_data_s = wdata_q;
        cm_mis_s  = mis_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    idx_d   = req_idx_s;
                    strb_d  = req_strobe;
                    wdata_d = req_data;
                    mis_d   = req_mis_s;
                    cnt_d   = LAT_CNT;
                    if (LATENCY == 0) begin
                        state_d   = ST_RESP;
                        cm_en_s   = 1'b1;
                        cm_idx_s  = req_idx_s;
                        cm_strb_s = req_strobe;
                        cm_data_s = req_data;
                        cm_mis_s  = req_mis_s;
                    end else begin
                        state_d   = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                    cm_en_s = 1'b1;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Read data is taken before this edge's write lands, so mixed-strobe accesses see old contents.
        if (cm_en_s) begin
            data_ok_d = 1'b1;
            err_d     = cm_mis_s;
            rdata_d   = cm_mis_s ? 64'd0 : mem_q[cm_idx_s];
        end else begin
            data_ok_d = 1'b0;
            err_d     = 1'b0;
            rdata_d   = 64'd0;
        end
    end

    // Control state, latched request and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            strb_q    <= 8'd0;
            wdata_q   <= 64'd0;
            mis_q     <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= 64'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
            mis_q     <= mis_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Backing store keeps its contents across reset; reset also blocks a same-edge commit.
    always_ff @(posedge clk) begin
        if (reset && cm_en_s && !cm_mis_s) begin
            for (int i = 0; i < 8; i++) begin
                if (cm_strb_s[i]) begin
                    mem_q[cm_idx_s][8*i +: 8] <= cm_data_s[8*i +: 8];
                end
            end
        end
    end

    assign resp_addr_ok = data_ok_q;
    assign resp_data_ok = data_ok_q;
    assign resp_data    = rdata_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Scoreboard bench: dut0 with LATENCY=2, dut1 with LATENCY=0; expectations queued at drive time.
module tb_dbus_responder;

    localparam logic [2:0] MS1 = 3'd0;
    localparam logic [2:0] MS4 = 3'd2;
    localparam logic [2:0] MS8 = 3'd3;

    typedef struct {
        int          dut;
        logic [63:0] data;
        bit          chk_data;
        int unsigned cyc;
        logic        err;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       valid_s;
    logic [1:0][63:0] addr_s;
    logic [1:0][2:0]  size_s;
    logic [1:0][7:0]  strb_s;
    logic [1:0][63:0] wdat_s;
    logic [1:0]       aok_s;
    logic [1:0]       ok_s;
    logic [1:0][63:0] rdata_s;
`ifdef DBUS_RESP_ALIGN_CHK_EN
    logic [1:0]       mis_s;
`endif

    int unsigned cyc   = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    exp_t        sb[$];
    exp_t        mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dbus_responder #(.LATENCY(2), .DEPTH(1024)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(valid_s[0]), .req_addr(addr_s[0]),
        .req_size(size_s[0]), .req_strobe(strb_s[0]), .req_data(wdat_s[0]),
        .resp_addr_ok(aok_s[0]), .resp_data_ok(ok_s[0]), .resp_data(rdata_s[0])
`ifdef DBUS_RESP_ALIGN_CHK_EN
        , .misalign_err(mis_s[0])
`endif
    );

    dbus_responder #(.LATENCY(0), .DEPTH(1024)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(valid_s[1]), .req_addr(addr_s[1]),
        .req_size(size_s[1]), .req_strobe(strb_s[1]), .req_data(wdat_s[1]),
        .resp_addr_ok(aok_s[1]), .resp_data_ok(ok_s[1]), .resp_data(rdata_s[1])
`ifdef DBUS_RESP_ALIGN_CHK_EN
        , .misalign_err(mis_s[1])
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // One request; optionally drops valid and scrambles fields right after capture.
    task automatic xact(input int d, input logic [63:0] addr, input logic [2:0] size,
                        input logic [7:0] strb, input logic [63:0] data,
                        input logic [63:0] exp_rd, input bit chk_rd, input logic exp_err,
                        input bit drop);
        exp_t e;
        bit   seen;
        @(negedge clk);
        valid_s[d] = 1'b1;
        addr_s[d]  = addr;
        size_s[d]  = size;
        strb_s[d]  = strb;
        wdat_s[d]  = data;
        e.dut = d; e.data = exp_rd; e.chk_data = chk_rd; e.err = exp_err;
        e.cyc = cyc + lat_of(d) + 1;
        sb.push_back(e);
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 1 && lat_of(d) > 0) begin
                chk("wait_ok", 64'(ok_s[d]), 64'd0);
                chk("wait_rdata", rdata_s[d], 64'd0);
            end
            if (k == 1 && drop) begin
                valid_s[d] = 1'b0;
                addr_s[d]  = ~addr;
                strb_s[d]  = 8'hFF;
                wdat_s[d]  = 64'hFEED_FACE_0BAD_F00D;
            end
            if (ok_s[d] === 1'b1) seen = 1'b1;
        end
        valid_s[d] = 1'b0;
        if (!seen) begin
            chk("timeout", 64'd0, 64'd1);
            sb.delete();
        end
    endtask

    // Zero-latency reads with valid held; next address presented on each data_ok.
    task automatic b2b(input logic [63:0] base, input logic [63:0] exp0, input logic [63:0] exp1,
                       input logic [63:0] exp2, input logic [63:0] exp3);
        logic [63:0] exps[4];
        exp_t        e;
        bit          seen;
        exps = '{exp0, exp1, exp2, exp3};
        @(negedge clk);
        valid_s[1] = 1'b1;
        size_s[1]  = MS8;
        strb_s[1]  = 8'h00;
        addr_s[1]  = base;
        e.dut = 1; e.data = exps[0]; e.chk_data = 1'b1; e.err = 1'b0; e.cyc = cyc + 1;
        sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            seen = 1'b0;
            for (int k = 1; k <= 10 && !seen; k++) begin
                @(negedge clk);
                if (ok_s[1] === 1'b1) seen = 1'b1;
            end
            if (!seen) begin
                chk("b2b_timeout", 64'd0, 64'd1);
                sb.delete();
                break;
            end
            if (i < 3) begin
                addr_s[1] = base + 64'(8 * (i + 1));
                e.data = exps[i+1]; e.cyc = cyc + 2;
                sb.push_back(e);
            end
        end
        valid_s[1] = 1'b0;
    endtask

    // Response monitor: every data_ok must match the oldest expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ok_s[d] === 1'b1) begin
                if (sb.size() == 0 || sb[0].dut != d) begin
                    chk("spurious_ok", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("latency", 64'(cyc), 64'(mon_e.cyc));
                    chk("addr_ok", 64'(aok_s[d]), 64'd1);
                    if (mon_e.chk_data) chk("rdata", rdata_s[d], mon_e.data);
`ifdef DBUS_RESP_ALIGN_CHK_EN
                    chk("misalign", 64'(mis_s[d]), 64'(mon_e.err));
`endif
                end
            end
        end
    end

    initial begin
        reset   = 1'b0;
        valid_s = '0;
        addr_s  = '0;
        size_s  = '0;
        strb_s  = '0;
        wdat_s  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ok0", 64'(ok_s[0]), 64'd0);
        chk("rst_aok0", 64'(aok_s[0]), 64'd0);
        chk("rst_rdata0", rdata_s[0], 64'd0);
        chk("rst_ok1", 64'(ok_s[1]), 64'd0);
        reset = 1'b1;

        // full write, read back, partial write with read-before-write, aliasing
        xact(0, 64'h10, MS8, 8'hFF, 64'h1122334455667788, 64'd0, 1'b0, 1'b0, 1'b0);
        xact(0, 64'h10, MS8, 8'h00, 64'd0, 64'h1122334455667788, 1'b1, 1'b0, 1'b0);
        xact(0, 64'h10, MS8, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 64'h1122334455667788, 1'b1, 1'b0, 1'b0);
        xact(0, 64'h10, MS8, 8'h00, 64'd0, 64'h11223344_BBBBBBBB, 1'b1, 1'b0, 1'b0);
        xact(0, 64'h8000_0000_0000_2017, MS1, 8'hF0, 64'hCCCCCCCC_00000000,
             64'h11223344_BBBBBBBB, 1'b1, 1'b0, 1'b0);
        xact(0, 64'h10, MS8, 8'h00, 64'd0, 64'hCCCCCCCC_BBBBBBBB, 1'b1, 1'b0, 1'b0);

        // reset in WAIT aborts a write to 0x20
        xact(0, 64'h20, MS8, 8'hFF, 64'h0123456789ABCDEF, 64'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        valid_s[0] = 1'b1; addr_s[0] = 64'h20; size_s[0] = MS8;
        strb_s[0] = 8'hFF; wdat_s[0] = 64'hDEAD;
        @(negedge clk);
        chk("abort_wait_ok", 64'(ok_s[0]), 64'd0);
        reset = 1'b0;
        valid_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_ok", 64'(ok_s[0]), 64'd0);
        end
        xact(0, 64'h20, MS8, 8'h00, 64'd0, 64'h0123456789ABCDEF, 1'b1, 1'b0, 1'b0);

        // valid dropped and fields scrambled after capture
        xact(0, 64'h30, MS8, 8'hFF, 64'h5555666677778888, 64'd0, 1'b0, 1'b0, 1'b1);
        xact(0, 64'h30, MS8, 8'h00, 64'd0, 64'h5555666677778888, 1'b1, 1'b0, 1'b0);

`ifdef DBUS_RESP_ALIGN_CHK_EN
        xact(0, 64'h12, MS4, 8'h3C, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 1'b1, 1'b1, 1'b0);
        xact(0, 64'h11, MS8, 8'h00, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0);
        xact(0, 64'h10, MS8, 8'h00, 64'd0, 64'hCCCCCCCC_BBBBBBBB, 1'b1, 1'b0, 1'b0);
`endif

        // zero-latency instance: fill, read-before-write, back-to-back reads
        xact(1, 64'h40, MS8, 8'hFF, 64'hA0A0A0A0_A0A0A0A0, 64'd0, 1'b0, 1'b0, 1'b0);
        xact(1, 64'h48, MS8, 8'hFF, 64'hB1B1B1B1_B1B1B1B1, 64'd0, 1'b0, 1'b0, 1'b0);
        xact(1, 64'h50, MS8, 8'hFF, 64'hC2C2C2C2_C2C2C2C2, 64'd0, 1'b0, 1'b0, 1'b0);
        xact(1, 64'h58, MS8, 8'hFF, 64'hD3D3D3D3_D3D3D3D3, 64'd0, 1'b0, 1'b0, 1'b0);
        xact(1, 64'h40, MS8, 8'h01, 64'h00000000_000000EE, 64'hA0A0A0A0_A0A0A0A0, 1'b1, 1'b0, 1'b0);
        b2b(64'h40, 64'hA0A0A0A0_A0A0A0EE, 64'hB1B1B1B1_B1B1B1B1,
            64'hC2C2C2C2_C2C2C2C2, 64'hD3D3D3D3_D3D3D3D3);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("idle_ok0", 64'(ok_s[0]), 64'd0);
        chk("idle_rdata1", rdata_s[1], 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
